elevator_ctrl: RTL and testbench

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

---
 rtl/elevator_ctrl.sv | 168 ++++++++++++++++
 tb/tb_elevator_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_ctrl.sv
// Three-floor elevator controller: homes to a known floor after reset, then
// serves latched floor requests with a scan (keep direction while requests
// lie ahead) policy, holding the door open for DOOR_CYC clocks at each stop.
//
// state | meaning
// ------+----------------------------------------------------------
// HOME  | position unknown, drive down until a floor sensor reports
// IDLE  | parked at a floor, door closed, choosing what to do next
// UP    | car travelling up
// DOWN  | car travelling down
// DOOR  | parked at a floor with the door open, timer running
module elevator_ctrl #(
    parameter int DOOR_CYC = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] story,
    input  logic [2:0] call,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic [2:0] pending,
    output logic       dir_up
);

    typedef enum logic [2:0] {HOME, IDLE, UP, DOWN, DOOR} state_t;

    localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYC - 1);

    state_t           state, state_nxt;
    state_t           depart_state;
    logic             depart_dir;
    logic             dir_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [2:0]       pending_nxt;
    logic             story_ok;
    logic [2:0]       here;
    logic             req_above, req_below;

    // Decode the floor sensor into a one-hot "this floor" mask and the
    // presence of latched requests strictly above / below it.
    always_comb begin
        story_ok  = 1'b0;
        here      = 3'b000;
        req_above = 1'b0;
        req_below = 1'b0;
        case (story)
            3'd1: begin
                story_ok  = 1'b1;
                here      = 3'b001;
                req_above = |(pending & 3'b110);
            end
            3'd2: begin
                story_ok  = 1'b1;
                here      = 3'b010;
                req_above = pending[2];
                req_below = pending[0];
            end
            3'd3: begin
                story_ok  = 1'b1;
                here      = 3'b100;
                req_below = |(pending & 3'b011);
            end
            default: ;
        endcase
    end

    // Scan policy when leaving a floor: keep direction if work lies ahead,
    // otherwise reverse if work lies behind, otherwise park.
    always_comb begin
        depart_state = IDLE;
        depart_dir   = dir_up;
        if (dir_up) begin
            if (req_above) begin
                depart_state = UP;
            end else if (req_below) begin
                depart_state = DOWN;
                depart_dir   = 1'b0;
            end
        end else begin
            if (req_below) begin
                depart_state = DOWN;
            end else if (req_above) begin
                depart_state = UP;
                depart_dir   = 1'b1;
            end
        end
    end

    // Next-state, direction, door timer and request latch.
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_up;
        timer_nxt = timer;
        case (state)
            HOME: begin
                if (story_ok) state_nxt = IDLE;
            end
            IDLE: begin
                if (!story_ok) begin
                    state_nxt = HOME;
                end else if (|(pending & here)) begin
                    state_nxt = DOOR;
                end else begin
                    state_nxt = depart_state;
                    dir_nxt   = depart_dir;
                end
            end
            UP: begin
                if (story_ok) begin
                    if (|(pending & here))  state_nxt = DOOR;
                    else if (story == 3'd3) state_nxt = IDLE;
                end
            end
            DOWN: begin
                if (story_ok) begin
                    if (|(pending & here))  state_nxt = DOOR;
                    else if (story == 3'd1) state_nxt = IDLE;
                end
            end
            DOOR: begin
                if (!story_ok) begin
                    state_nxt = HOME;
                end else if (|(call & here)) begin
                    timer_nxt = DOOR_LOAD;
                end else if (timer != '0) begin
                    timer_nxt = timer - CNT_W'(1);
                end else begin
                    state_nxt = depart_state;
                    dir_nxt   = depart_dir;
                end
            end
            default: state_nxt = HOME;
        endcase

        if (state_nxt == DOOR && state != DOOR) timer_nxt = DOOR_LOAD;

        // While the door is (or is about to be) open at a floor, that floor's
        // request is served: clear it and ignore fresh calls for it.
        if (state_nxt == DOOR) pending_nxt = (pending | call) & ~here;
        else                   pending_nxt = pending | call;
    end

    // State register; reset drops all requests and restarts homing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HOME;
            pending <= 3'b000;
            dir_up  <= 1'b1;
            timer   <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            dir_up  <= dir_nxt;
            timer   <= timer_nxt;
        end
    end

    // Outputs come from the registered state only, so motors and door are
    // mutually exclusive by construction.
    always_comb begin
        motor_up   = (state == UP);
        motor_down = (state == HOME) || (state == DOWN);
        door_open  = (state == DOOR);
    end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl: a floor-level behavioural model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_elevator_ctrl;

    localparam int DOOR_CYC = 8;

    localparam logic [2:0] M_HOME = 3'd0;
    localparam logic [2:0] M_IDLE = 3'd1;
    localparam logic [2:0] M_UP   = 3'd2;
    localparam logic [2:0] M_DOWN = 3'd3;
    localparam logic [2:0] M_DOOR = 3'd4;

    logic       clk;
    logic       rst_n;
    logic [2:0] story;
    logic [2:0] call;
    logic       motor_up, motor_down, door_open, dir_up;
    logic [2:0] pending;

    int checks;
    int errors;

    elevator_ctrl #(.DOOR_CYC(DOOR_CYC), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .story      (story),
        .call       (call),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .door_open  (door_open),
        .pending    (pending),
        .dir_up     (dir_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: what the car is doing, which floors still want service, which
    // way it scans, and how many door-open clocks remain.
    typedef struct packed {
        logic [2:0] mode;
        logic [2:0] pend;
        logic       dir;
        logic [4:0] left;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(mstate_t s, logic [2:0] st, logic [2:0] c);
        mstate_t n;
        bit      at_floor;
        int      f;
        bit      work_up, work_dn;
        n        = s;
        at_floor = (st >= 3'd1) && (st <= 3'd3);
        f        = at_floor ? int'(st) - 1 : 0;
        work_up  = 0;
        work_dn  = 0;
        for (int i = 0; i < 3; i++) begin
            if (s.pend[i] && at_floor && i > f) work_up = 1;
            if (s.pend[i] && at_floor && i < f) work_dn = 1;
        end
        n.pend = s.pend | c;
        case (s.mode)
            M_HOME: if (at_floor) n.mode = M_IDLE;
            M_UP: begin
                if (at_floor && s.pend[f]) n.mode = M_DOOR;
                else if (at_floor && f == 2) n.mode = M_IDLE;
            end
            M_DOWN: begin
                if (at_floor && s.pend[f]) n.mode = M_DOOR;
                else if (at_floor && f == 0) n.mode = M_IDLE;
            end
            default: begin
                if (!at_floor) begin
                    n.mode = M_HOME;
                end else if (s.mode == M_IDLE && s.pend[f]) begin
                    n.mode = M_DOOR;
                end else if (s.mode == M_DOOR && c[f]) begin
                    n.left = 5'(DOOR_CYC);
                end else if (s.mode == M_DOOR && s.left > 5'd1) begin
                    n.left = s.left - 5'd1;
                end else begin
                    if (s.dir && work_up)       n.mode = M_UP;
                    else if (s.dir && work_dn)  begin n.mode = M_DOWN; n.dir = 1'b0; end
                    else if (!s.dir && work_dn) n.mode = M_DOWN;
                    else if (!s.dir && work_up) begin n.mode = M_UP; n.dir = 1'b1; end
                    else                        n.mode = M_IDLE;
                end
            end
        endcase
        if (n.mode == M_DOOR) n.pend[f] = 1'b0;
        if (n.mode == M_DOOR && s.mode != M_DOOR) n.left = 5'(DOOR_CYC);
        return n;
    endfunction

    // Advance the model alongside the DUT, including asynchronous reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{mode: M_HOME, pend: 3'b000, dir: 1'b1, left: 5'd0};
        else        m <= model_next(m, story, call);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Count consecutive door-open clocks starting now; stops once the door
    // has opened and closed again, or after a bounded number of clocks.
    task automatic count_door(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (door_open) n++;
            else if (n > 0) break;
            tick();
        end
    endtask

    int n;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        story  = 3'd0;
        call   = 3'b000;

        fork
            forever begin
                @(negedge clk);
                checks++;
                if ({motor_up, motor_down, door_open, pending, dir_up} !==
                    {m.mode == M_UP, (m.mode == M_HOME) || (m.mode == M_DOWN),
                     m.mode == M_DOOR, m.pend, m.dir}) begin
                    errors++;
                    $display("FAIL model t=%0t: got up=%b dn=%b door=%b pend=%b dir=%b expected mode=%0d pend=%b dir=%b",
                             $time, motor_up, motor_down, door_open, pending, dir_up,
                             m.mode, m.pend, m.dir);
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: simulation did not finish in time");
                $fatal(1, "watchdog");
            end
        join_none

        // Homing
        repeat (3) tick();
        check("rst_pending", int'(pending), 0);
        check("rst_motor_down", int'(motor_down), 1);
        check("rst_dir_up", int'(dir_up), 1);
        rst_n = 1'b1;
        n = 0;
        repeat (5) begin
            tick();
            if (motor_down && !motor_up) n++;
        end
        check("home_down_clocks", n, 5);
        story = 3'd1;
        tick();
        check("home_idle_motors", int'({motor_up, motor_down, door_open}), 0);
        check("home_idle_pending", int'(pending), 0);

        // Same-floor call
        call = 3'b001;
        tick();
        call = 3'b000;
        check("same_pend_latched", int'(pending), 1);
        count_door(n);
        check("same_door_clocks", n, 8);
        check("same_pend_cleared", int'(pending), 0);
        check("same_no_motor", int'({motor_up, motor_down}), 0);

        // Intermediate stop on the way up
        call = 3'b110;
        tick();
        call = 3'b000;
        tick();
        check("mid_motor_up", int'(motor_up), 1);
        story = 3'd0;
        tick();
        check("mid_between_floors_up", int'(motor_up), 1);
        story = 3'd2;
        tick();
        check("mid_door_f2", int'(door_open), 1);
        check("mid_pend_f2", int'(pending), 4);
        count_door(n);
        check("mid_door_f2_clocks", n, 8);
        check("mid_resume_up", int'(motor_up), 1);
        story = 3'd3;
        tick();
        check("mid_door_f3", int'(door_open), 1);
        check("mid_pend_f3", int'(pending), 0);
        count_door(n);
        check("mid_door_f3_clocks", n, 8);
        check("mid_idle_f3", int'({motor_up, motor_down, door_open}), 0);

        // Direction preference from floor 2
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        story = 3'd2;
        tick();
        call = 3'b101;
        tick();
        call = 3'b000;
        check("dir_pend_101", int'(pending), 5);
        tick();
        check("dir_up_first", int'(motor_up), 1);
        check("dir_up_flag", int'(dir_up), 1);
        story = 3'd3;
        tick();
        check("dir_pend_after_f3", int'(pending), 1);
        count_door(n);
        check("dir_door_f3_clocks", n, 8);
        check("dir_reverse_down", int'(motor_down), 1);
        check("dir_flag_toggled", int'(dir_up), 0);
        story = 3'd2;
        tick();
        check("dir_pass_f2", int'(motor_down), 1);
        story = 3'd1;
        tick();
        check("dir_door_f1", int'(door_open), 1);
        check("dir_pend_empty", int'(pending), 0);
        count_door(n);
        check("dir_door_f1_clocks", n, 8);

        // Door hold at floor 2
        call = 3'b010;
        tick();
        call = 3'b000;
        tick();
        check("hold_up_reversed", int'(motor_up), 1);
        check("hold_dir_up", int'(dir_up), 1);
        story = 3'd2;
        tick();
        check("hold_door_open", int'(door_open), 1);
        repeat (5) tick();
        call = 3'b010;
        tick();
        call = 3'b000;
        check("hold_no_pending", int'(pending), 0);
        count_door(n);
        check("hold_total_clocks", 6 + n, 14);
        check("hold_idle_after", int'({motor_up, motor_down, door_open}), 0);

        // Reset while moving up
        call = 3'b100;
        tick();
        call = 3'b000;
        tick();
        check("rstmove_up", int'(motor_up), 1);
        check("rstmove_pend", int'(pending), 4);
        rst_n = 1'b0;
        #1;
        check("rstmove_up_drop", int'(motor_up), 0);
        check("rstmove_down", int'(motor_down), 1);
        check("rstmove_pend_clr", int'(pending), 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("rstmove_rehome", int'({motor_up, motor_down, door_open}), 0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
